// File: rtl/vga_pattern_gen_pkg.sv
// vga_pattern_gen_pkg
// Shared definitions for the VGA pattern generator: pattern mode encoding,
// frame counter width and a small bar-index helper.
package vga_pattern_gen_pkg;

  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  // Bar index advances to the next bar but sticks on the last one (white).
  function automatic logic [2:0] bar_next(input logic [2:0] idx);
    return (idx == 3'd7) ? idx : idx + 3'd1;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if
// Bundles the tracker-side inputs and the DAC-side outputs of the pattern
// generator.
//   i_h_sync, i_v_sync, i_visible : tracker strobes
//   i_x, i_y                      : visible-area coordinates
//   i_mode                        : requested pattern (latched per frame)
//   i_color                       : solid colour {r,g,b}
//   o_r, o_g, o_b                 : registered pixel colour
//   o_h_sync, o_v_sync, o_visible : strobes aligned with the colour
// master drives the tracker side, slave is the generator.
interface vga_pattern_gen_if #(
  parameter int CNT_WIDTH   = 10,
  parameter int COLOR_WIDTH = 4
);
  logic                     i_h_sync;
  logic                     i_v_sync;
  logic                     i_visible;
  logic [CNT_WIDTH-1:0]     i_x;
  logic [CNT_WIDTH-1:0]     i_y;
  logic [1:0]               i_mode;
  logic [3*COLOR_WIDTH-1:0] i_color;
  logic [COLOR_WIDTH-1:0]   o_r;
  logic [COLOR_WIDTH-1:0]   o_g;
  logic [COLOR_WIDTH-1:0]   o_b;
  logic                     o_h_sync;
  logic                     o_v_sync;
  logic                     o_visible;

  modport master (
    output i_h_sync, i_v_sync, i_visible, i_x, i_y, i_mode, i_color,
    input  o_r, o_g, o_b, o_h_sync, o_v_sync, o_visible
  );

  modport slave (
    input  i_h_sync, i_v_sync, i_visible, i_x, i_y, i_mode, i_color,
    output o_r, o_g, o_b, o_h_sync, o_v_sync, o_visible
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Fixed-depth register delay with synchronous active-low reset; every tap
// is flushed to RST_VAL on reset.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   d     : input word
//   q     : d delayed by DEPTH cycles
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= {DEPTH{RST_VAL}};
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Test-pattern source behind the VGA area tracker. Produces registered RGB
// with syncs/visible delayed to match (2-cycle latency on every output).
// Patterns: solid, colour bars, checkerboard, animated gradient; the pattern
// is latched at each frame start (v_sync going active).
//   i_clk   : pixel clock
//   i_rst_n : synchronous active-low reset
//   bus     : tracker inputs / DAC outputs (vga_pattern_gen_if.slave)
import vga_pattern_gen_pkg::*;

module vga_pattern_gen #(
  parameter int   CNT_WIDTH   = 10,
  parameter int   COLOR_WIDTH = 4,
  parameter int   BAR_WIDTH   = 80,
  parameter int   CHECK_LOG2  = 4,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input logic         i_clk,
  input logic         i_rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int CW    = COLOR_WIDTH;
  localparam int PIX_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [2:0] CTL_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  // Syncs and visible only need delaying.
  logic [2:0] ctl_q;

  vga_delay_line #(.WIDTH(3), .DEPTH(2), .RST_VAL(CTL_RST)) u_ctl_dly (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     ({bus.i_h_sync, bus.i_v_sync, bus.i_visible}),
    .q     (ctl_q)
  );

  assign bus.o_h_sync  = ctl_q[2];
  assign bus.o_v_sync  = ctl_q[1];
  assign bus.o_visible = ctl_q[0];

  // Frame start detection. 'armed' blocks the first cycle after reset so a
  // sync that is already active at release is not seen as an edge.
  logic                   vs_q;
  logic                   armed;
  logic                   frame_start;
  mode_e                  mode;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  assign frame_start = armed && (bus.i_v_sync == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_q      <= ~SYNC_ACTIVE;
      armed     <= 1'b0;
      mode      <= MODE_SOLID;
      frame_cnt <= '0;
    end else begin
      vs_q  <= bus.i_v_sync;
      armed <= 1'b1;
      if (frame_start) begin
        mode      <= mode_e'(bus.i_mode);
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Bar counters track the position of the pixel arriving next; the
  // current value is captured into stage 0 alongside the coordinates.
  logic [PIX_W-1:0] pix_cnt;
  logic [2:0]       bar_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !bus.i_visible) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_cnt == PIX_W'(BAR_WIDTH - 1)) begin
      pix_cnt <= '0;
      bar_idx <= bar_next(bar_idx);
    end else begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Stage 0: registered pixel inputs.
  logic                 vis_s0;
  logic [CNT_WIDTH-1:0] x_s0;
  logic [CNT_WIDTH-1:0] y_s0;
  logic [2:0]           bar_s0;
  logic [3*CW-1:0]      color_s0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vis_s0   <= 1'b0;
      x_s0     <= '0;
      y_s0     <= '0;
      bar_s0   <= '0;
      color_s0 <= '0;
    end else begin
      vis_s0   <= bus.i_visible;
      x_s0     <= bus.i_x;
      y_s0     <= bus.i_y;
      bar_s0   <= bar_idx;
      color_s0 <= bus.i_color;
    end
  end

  // Stage 1: colour selection and blanking.
  logic [CNT_WIDTH+FRAME_CNT_W-1:0] grad_sum;
  logic [3*CW-1:0]                  rgb_next;
  logic [3*CW-1:0]                  rgb_s1;
  logic                             unused_bits;

  assign grad_sum    = {{FRAME_CNT_W{1'b0}}, x_s0} + {{CNT_WIDTH{1'b0}}, frame_cnt};
  assign unused_bits = ^{grad_sum[CNT_WIDTH+FRAME_CNT_W-1:CW], y_s0};

  always_comb begin
    rgb_next = '0;
    case (mode)
      MODE_SOLID:    rgb_next = color_s0;
      MODE_BARS:     rgb_next = {{CW{bar_s0[2]}}, {CW{bar_s0[1]}}, {CW{bar_s0[0]}}};
      MODE_CHECKER:  rgb_next = {(3*CW){x_s0[CHECK_LOG2] ^ y_s0[CHECK_LOG2]}};
      MODE_GRADIENT: rgb_next = {grad_sum[CW-1:0], y_s0[CW-1:0],
                                 frame_cnt[FRAME_CNT_W-1 -: CW]};
      default:       rgb_next = '0;
    endcase
    if (!vis_s0) rgb_next = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rgb_s1 <= '0;
    else          rgb_s1 <= rgb_next;
  end

  assign bus.o_r = rgb_s1[3*CW-1:2*CW];
  assign bus.o_g = rgb_s1[2*CW-1:CW];
  assign bus.o_b = rgb_s1[CW-1:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
// Directed bench: reset/release sequence, a table of per-pixel vectors
// (latency, solid, blanking, bars, checker, mode latch, gradient), frame
// counter wrap and a mid-frame reset.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.CNT_WIDTH(10), .COLOR_WIDTH(4)) bus ();

  vga_pattern_gen #(
    .CNT_WIDTH   (10),
    .COLOR_WIDTH (4),
    .BAR_WIDTH   (2),
    .CHECK_LOG2  (1),
    .SYNC_ACTIVE (1'b0)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       h;
    logic       v;
    logic       vis;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] mode;
    logic [11:0] color;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  task automatic drive(input logic h, input logic v, input logic vis,
                       input logic [9:0] x, input logic [9:0] y,
                       input logic [1:0] mode, input logic [11:0] color);
    bus.i_h_sync  = h;
    bus.i_v_sync  = v;
    bus.i_visible = vis;
    bus.i_x       = x;
    bus.i_y       = y;
    bus.i_mode    = mode;
    bus.i_color   = color;
  endtask

  task automatic add(input logic h, input logic v, input logic vis,
                     input logic [9:0] x, input logic [9:0] y,
                     input logic [1:0] mode, input logic [11:0] color,
                     input logic [11:0] exp_rgb);
    vec_t e;
    e.h = h; e.v = v; e.vis = vis; e.x = x; e.y = y;
    e.mode = mode; e.color = color; e.exp_rgb = exp_rgb;
    tbl.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] exp_rgb,
                       input logic eh, input logic ev, input logic evis);
    logic [14:0] act;
    logic [14:0] exp_v;
    act   = {bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_visible};
    exp_v = {exp_rgb, eh, ev, evis};
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got rgb=%h h=%b v=%b vis=%b, expected rgb=%h h=%b v=%b vis=%b",
                  name, act[14:3], act[2], act[1], act[0], exp_rgb, eh, ev, evis);
  endtask

  task automatic frame_pulse();
    drive(1, 0, 0, 0, 0, 3, 12'h000);
    tick();
    drive(1, 1, 0, 0, 0, 3, 12'h000);
    tick();
  endtask

  logic [11:0] bar_exp [20] = '{
    12'h000, 12'h000, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0, 12'h0FF, 12'h0FF,
    12'hF00, 12'hF00, 12'hF0F, 12'hF0F, 12'hFF0, 12'hFF0,
    12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF
  };

  initial begin
    // ---- vector table ----
    // solid colour, one-cycle h_sync pulse, blanking
    add(1, 1, 1, 0, 0, 0, 12'h123, 12'h123);
    add(0, 1, 1, 1, 0, 0, 12'h123, 12'h123);
    add(1, 1, 0, 2, 0, 0, 12'hFFF, 12'h000);
    add(1, 1, 1, 3, 0, 0, 12'hFFF, 12'hFFF);
    // frame start -> bars; mode input changed mid-frame is ignored
    add(1, 0, 0, 0, 0, 1, 12'h000, 12'h000);
    add(1, 1, 0, 0, 0, 1, 12'h000, 12'h000);
    for (int i = 0; i < 20; i++) add(1, 1, 1, 10'(i), 0, 2, 12'h000, bar_exp[i]);
    add(1, 1, 0, 0, 0, 2, 12'h000, 12'h000);
    // frame start -> checker (square side 2)
    add(1, 0, 0, 0, 0, 2, 12'h000, 12'h000);
    add(1, 1, 0, 0, 0, 2, 12'h000, 12'h000);
    add(1, 1, 1, 0, 0, 3, 12'h123, 12'h000);
    add(1, 1, 1, 1, 0, 3, 12'h123, 12'h000);
    add(1, 1, 1, 2, 0, 3, 12'h123, 12'hFFF);
    add(1, 1, 1, 3, 0, 3, 12'h123, 12'hFFF);
    add(1, 1, 1, 0, 2, 3, 12'h123, 12'hFFF);
    add(1, 1, 1, 1, 2, 3, 12'h123, 12'hFFF);
    add(1, 1, 1, 2, 2, 3, 12'h123, 12'h000);
    add(1, 1, 1, 3, 2, 3, 12'h123, 12'h000);
    // frame start -> solid (frame 3); mode 3 requested mid-frame
    add(1, 0, 0, 0, 0, 0, 12'hABC, 12'h000);
    add(1, 1, 0, 0, 0, 0, 12'hABC, 12'h000);
    add(1, 1, 1, 0, 0, 3, 12'hABC, 12'hABC);
    add(1, 1, 1, 5, 0, 3, 12'hABC, 12'hABC);
    // frame start -> gradient with frame_cnt = 4
    add(1, 0, 0, 0, 0, 3, 12'hABC, 12'h000);
    add(1, 1, 0, 0, 0, 3, 12'hABC, 12'h000);
    add(1, 1, 1, 5, 6, 3, 12'hABC, 12'h960);
    add(1, 1, 1, 14, 10'h13, 3, 12'hABC, 12'h230);

    // ---- reset: syncs held active, visible high ----
    rst_n = 1'b0;
    drive(0, 0, 1, 3, 0, 3, 12'hFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold%0d", i), 12'h000, 1, 1, 0);
    end
    rst_n = 1'b1;
    tick();
    check("rst_flush", 12'h000, 1, 1, 0);
    tick();
    check("rst_first_data", 12'hFFF, 0, 0, 1);
    // v_sync active at release must not latch mode 3
    drive(1, 1, 1, 0, 0, 3, 12'h5A3);
    tick();
    tick();
    check("no_frame_at_release", 12'h5A3, 1, 1, 1);

    // ---- table: output after vector k's edge shows vector k-1 ----
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].h, tbl[k].v, tbl[k].vis, tbl[k].x, tbl[k].y, tbl[k].mode, tbl[k].color);
      tick();
      if (k > 0)
        check($sformatf("vec%0d", k - 1), tbl[k-1].exp_rgb, tbl[k-1].h, tbl[k-1].v, tbl[k-1].vis);
    end
    drive(1, 1, 0, 0, 0, 3, 12'h000);
    tick();
    check($sformatf("vec%0d", tbl.size() - 1), tbl[tbl.size()-1].exp_rgb,
          tbl[tbl.size()-1].h, tbl[tbl.size()-1].v, tbl[tbl.size()-1].vis);

    // ---- frame counter wrap: 4 -> 255 -> 0 ----
    for (int f = 0; f < 251; f++) frame_pulse();
    drive(1, 1, 1, 0, 7, 3, 12'h000);
    tick();
    drive(1, 1, 0, 0, 0, 3, 12'h000);
    tick();
    check("frame_255", 12'hF7F, 1, 1, 1);
    frame_pulse();
    drive(1, 1, 1, 1, 7, 3, 12'h000);
    tick();
    drive(1, 1, 0, 0, 0, 3, 12'h000);
    tick();
    check("frame_wrap0", 12'h170, 1, 1, 1);

    // ---- mid-frame reset returns to solid mode ----
    drive(1, 1, 1, 2, 0, 3, 12'h5A3);
    rst_n = 1'b0;
    tick();
    check("mid_rst", 12'h000, 1, 1, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_flush", 12'h000, 1, 1, 0);
    tick();
    check("mid_rst_mode0", 12'h5A3, 1, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
